// File: rtl/lenet_layer_sequencer_if.sv
// Control/status bundle between the top-level start/status logic and the layer sequencer.
// Build option SEQ_PERF_CNT_EN adds the layer_cycles/total_cycles performance outputs.
interface lenet_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_W    = 2,
  parameter int TIMEOUT_W  = 20
) ();
  logic                  start;
  logic                  abort;
  logic [TIMEOUT_W-1:0]  timeout_lim;
  logic [NUM_LAYERS-1:0] layer_finish;
  logic [NUM_LAYERS-1:0] layer_en;
  logic [LAYER_W-1:0]    cur_layer;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [LAYER_W-1:0]    err_layer;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]           layer_cycles;
  logic [31:0]           total_cycles;
`endif

  modport master (
    output start, abort, timeout_lim, layer_finish,
`ifdef SEQ_PERF_CNT_EN
    input  layer_cycles, total_cycles,
`endif
    input  layer_en, cur_layer, busy, done, err, err_layer
  );

  modport slave (
    input  start, abort, timeout_lim, layer_finish,
`ifdef SEQ_PERF_CNT_EN
    output layer_cycles, total_cycles,
`endif
    output layer_en, cur_layer, busy, done, err, err_layer
  );
endinterface

// File: rtl/lenet_layer_sequencer.sv
// Runs NUM_LAYERS LeNet layers in order with dead gaps, per-layer watchdog, abort and done pulse.
// Build option SEQ_PERF_CNT_EN adds saturating per-layer and per-run cycle counters.
module lenet_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_W    = 2,
  parameter int TIMEOUT_W  = 20,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lenet_layer_sequencer_if.slave sif,
  output logic [2:0]             o_dbg_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                r_state;
  logic [NUM_LAYERS-1:0] r_layer_en;
  logic [LAYER_W-1:0]    r_cur_layer;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [LAYER_W-1:0]    r_err_layer;
  logic [TIMEOUT_W-1:0]  r_wd_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;

  logic w_fin;
  logic w_last;
  logic w_tmo;
  logic w_start;
  logic w_gap_end;

  // Layer handshake: layer_en[k] is held until the layer raises layer_finish[k]; finish is
  // sampled only while RUN k, so extra or lingering finish bits never advance the sequence.
  assign w_fin     = sif.layer_finish[r_cur_layer];
  assign w_last    = (r_cur_layer == LAYER_W'(NUM_LAYERS - 1));
  assign w_tmo     = (sif.timeout_lim != '0) && (r_wd_cnt >= (sif.timeout_lim - TIMEOUT_W'(1)));
  assign w_start   = sif.start && !sif.abort;
  assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_layer_en  <= '0;
      r_cur_layer <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_layer <= '0;
      r_wd_cnt    <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_RUN;
            r_cur_layer <= '0;
            r_layer_en  <= NUM_LAYERS'(1);
            r_busy      <= 1'b1;
            r_wd_cnt    <= '0;
          end
        end

        S_RUN: begin
          if (sif.abort) begin
            r_state    <= S_IDLE;
            r_layer_en <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
          end else if (w_fin) begin
            r_layer_en <= '0;
            r_wd_cnt   <= '0;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end else if (w_tmo) begin
            r_state     <= S_ERR;
            r_layer_en  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
            r_err_layer <= r_cur_layer;
          end else if (r_wd_cnt != '1) begin
            // saturate rather than wrap so a disabled watchdog never re-arms spuriously
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (sif.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_gap_end) begin
            r_state     <= S_RUN;
            r_cur_layer <= r_cur_layer + 1'b1;
            r_layer_en  <= NUM_LAYERS'(1) << (r_cur_layer + 1'b1);
            r_wd_cnt    <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end

        S_ERR: begin
          if (sif.abort) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end else if (sif.start) begin
            r_state     <= S_RUN;
            r_err       <= 1'b0;
            r_cur_layer <= '0;
            r_layer_en  <= NUM_LAYERS'(1);
            r_busy      <= 1'b1;
            r_wd_cnt    <= '0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_layer_en <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign sif.layer_en  = r_layer_en;
  assign sif.cur_layer = r_cur_layer;
  assign sif.busy      = r_busy;
  assign sif.done      = r_done;
  assign sif.err       = r_err;
  assign sif.err_layer = r_err_layer;
  assign o_dbg_state   = r_state;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_layer_cycles;
  logic [31:0] r_total_cycles;
  logic [31:0] r_lay_cnt;
  logic [31:0] r_tot_cnt;
  logic        w_accept;
  logic        w_run_live;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_ERR)) && w_start;
  assign w_run_live = (r_state == S_RUN) && !sif.abort;

  // r_lay_cnt holds enable cycles already completed in this layer; the finish cycle adds one.
  // r_tot_cnt starts at 1 to include the start-accept cycle itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_layer_cycles <= '0;
      r_total_cycles <= '0;
      r_lay_cnt      <= '0;
      r_tot_cnt      <= '0;
    end else if (w_accept) begin
      r_layer_cycles <= '0;
      r_total_cycles <= '0;
      r_lay_cnt      <= '0;
      r_tot_cnt      <= 32'd1;
    end else begin
      r_lay_cnt <= (w_run_live && !w_fin) ? sat_inc(r_lay_cnt) : '0;
      if (((r_state == S_RUN) || (r_state == S_GAP)) && !sif.abort) begin
        r_tot_cnt <= sat_inc(r_tot_cnt);
      end
      if (w_run_live && w_fin) begin
        r_layer_cycles <= sat_inc(r_lay_cnt);
        if (w_last) begin
          r_total_cycles <= sat_inc(r_tot_cnt);
        end
      end
    end
  end

  assign sif.layer_cycles = r_layer_cycles;
  assign sif.total_cycles = r_total_cycles;
`endif

endmodule
